// File: rtl/ifetch32_pkg.sv
// Shared definitions for the multi-cycle instruction fetch unit: FSM state
// encoding, reset vector default and instruction field positions.
// Optional feature macro: IFETCH32_ALIGN_CHK_EN (adds the FAULT state).
package ifetch32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // J-type target field and the PC region bits kept across a jump
  localparam int JTGT_MSB  = 25;
  localparam int JTGT_LSB  = 0;
  localparam int PC_HI_MSB = 31;
  localparam int PC_HI_LSB = 28;

`ifdef IFETCH32_ALIGN_CHK_EN
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_e;
`endif

  // Sequential successor; wraps modulo 2^32 naturally
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch32_npc.sv
// Next-PC selection for ifetch32_mc (purely combinational).
// Priority: jr, then j/jal, then taken branch, else fall-through.
// Without IFETCH32_ALIGN_CHK_EN the result is forced word-aligned; with it the
// raw target is passed on so the parent can detect misalignment.
module ifetch32_npc
  import ifetch32_pkg::*;
(
  input  logic        branch,
  input  logic        nbranch,
  input  logic        jmp,
  input  logic        jal,
  input  logic        jrn,
  input  logic        zero,
  input  logic [31:0] addr_result,
  input  logic [31:0] read_data_1,
  input  logic [31:0] opcplus4,
  input  logic [25:0] jtarget,
  output logic [31:0] npc
);

  // Prioritised target mux; jr wins even on an illegal jr+jal decode
  always_comb begin
    npc = opcplus4;
    if (jrn) begin
      npc = read_data_1;
    end else if (jmp | jal) begin
      npc = {opcplus4[PC_HI_MSB:PC_HI_LSB], jtarget, 2'b00};
    end else if ((branch & zero) | (nbranch & ~zero)) begin
      npc = addr_result;
    end
`ifndef IFETCH32_ALIGN_CHK_EN
    npc[1:0] = 2'b00;
`endif
  end

endmodule

// File: rtl/ifetch32_mc.sv
// Multi-cycle instruction fetch unit: FETCH issues a memory read and waits
// for ack, EXEC presents the instruction to the core until it stops stalling,
// then the next PC is loaded and a new fetch starts.
// Optional feature macro: IFETCH32_ALIGN_CHK_EN -- adds the fault output and
// a sticky FAULT state entered on a misaligned next-PC.
module ifetch32_mc
  import ifetch32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jrn,
  input  logic        Zero,
  input  logic [31:0] Addr_result,
  input  logic [31:0] Read_data_1,
  input  logic        stall,
  output logic [31:0] Instruction,
  output logic [31:0] opcplus4,
  output logic        instr_valid
`ifdef IFETCH32_ALIGN_CHK_EN
  ,
  output logic        fault
`endif
);

  state_e      state;
  logic [31:0] pc;
  logic [31:0] npc;

  ifetch32_npc u_npc (
    .branch      (Branch),
    .nbranch     (nBranch),
    .jmp         (Jmp),
    .jal         (Jal),
    .jrn         (Jrn),
    .zero        (Zero),
    .addr_result (Addr_result),
    .read_data_1 (Read_data_1),
    .opcplus4    (opcplus4),
    .jtarget     (Instruction[JTGT_MSB:JTGT_LSB]),
    .npc         (npc)
  );

  // Request is gated by reset_n so it drops the instant reset asserts and
  // rises in the very first cycle after release.
  assign imem_req    = reset_n && (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == EXEC);
`ifdef IFETCH32_ALIGN_CHK_EN
  assign fault       = (state == FAULT);
`endif

  // Fetch/execute handshake: capture on ack, advance PC when the core releases
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      Instruction <= '0;
      opcplus4    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            Instruction <= imem_rdata;
            opcplus4    <= pc_plus4(pc);
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
`ifdef IFETCH32_ALIGN_CHK_EN
            if (npc[1:0] != 2'b00) begin
              state <= FAULT;
            end else begin
              pc    <= npc;
              state <= FETCH;
            end
`else
            pc    <= npc;
            state <= FETCH;
`endif
          end
        end
`ifdef IFETCH32_ALIGN_CHK_EN
        FAULT: begin
          state <= FAULT;
        end
`endif
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/ifetch32_mc.md
IFETCH32_MC -- requirements
Module: ifetch32_mc

Interface
REQ-001 SHALL have the parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have the port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have the port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 SHALL have the port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-006 SHALL have the port imem_ack, input, 1 bit: memory returns imem_rdata this cycle.
REQ-007 SHALL have the port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 SHALL have the ports Branch, nBranch, Jmp, Jal and Jrn, each input, 1 bit: control-unit flow decode of the current Instruction.
REQ-009 SHALL have the port Zero, input, 1 bit: ALU zero flag.
REQ-010 SHALL have the port Addr_result, input, 32 bits: branch target from execute.
REQ-011 SHALL have the port Read_data_1, input, 32 bits: rs value, the jr target.
REQ-012 SHALL have the port stall, input, 1 bit: core holds the current instruction.
REQ-013 SHALL have the port Instruction, output, 32 bits: registered current instruction.
REQ-014 SHALL have the port opcplus4, output, 32 bits: PC+4 of the current Instruction, the JAL link value.
REQ-015 SHALL have the port instr_valid, output, 1 bit: Instruction and opcplus4 are valid for the core.

Function
REQ-016 SHALL implement the states FETCH and EXEC, plus FAULT when IFETCH32_ALIGN_CHK_EN is defined.
REQ-017 In FETCH, SHALL drive imem_req=1 with imem_addr=PC, holding both stable until imem_ack=1.
REQ-018 On imem_ack in FETCH, SHALL capture imem_rdata into Instruction and PC+4 into opcplus4, then go to EXEC; ack in the request cycle is legal (minimum latency 1 cycle, req to valid).
REQ-019 In EXEC, SHALL drive instr_valid=1 and imem_req=0; imem_ack SHALL be ignored outside FETCH.
REQ-020 In EXEC with stall=1, SHALL remain in EXEC with Instruction, opcplus4 and PC frozen.
REQ-021 In EXEC with stall=0, SHALL load PC with next-PC and return to FETCH at the clock edge.
REQ-022 Next-PC priority SHALL be: Jrn -> Read_data_1; else Jmp|Jal -> {opcplus4[31:28], Instruction[25:0], 2'b00}; else (Branch&Zero)|(nBranch&~Zero) -> Addr_result; else opcplus4.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Simultaneous Jrn and Jmp/Jal (illegal decode) SHALL resolve to Jrn per REQ-022.

Reset
REQ-025 reset_n=0 SHALL immediately force PC=RESET_PC, state=FETCH, Instruction=0, opcplus4=0, instr_valid=0, imem_req=0 (and fault=0 when present).
REQ-026 The first imem_req=1 SHALL appear in the first cycle after reset_n deasserts; an ack arriving during or straddling reset SHALL be discarded.

Configuration
REQ-027 With IFETCH32_ALIGN_CHK_EN defined, SHALL add the port fault (output, 1 bit), and a next-PC with bits[1:0]!=0 SHALL enter FAULT (fault=1, imem_req=0, instr_valid=0) until reset.
REQ-028 Without IFETCH32_ALIGN_CHK_EN, SHALL force next-PC bits[1:0] to 2'b00, and SHALL have neither the fault port nor the FAULT state.

Structure
REQ-029 Package ifetch32_pkg SHALL hold the state enum, the RESET_PC default and the instruction field position constants.
REQ-030 Next-PC selection SHALL be the combinational sub-module ifetch32_npc; state, PC and handshake SHALL stay in ifetch32_mc.

Verification
REQ-031 Release reset, ack after 3 wait cycles with rdata 32'h2008_0005 -> imem_addr=0 held 4 cycles; Instruction=32'h2008_0005, opcplus4=4, instr_valid=1 the following cycle.
REQ-032 Sequential flow with zero-wait ack -> fetch addresses 0,4,8,C, one instruction per 2 cycles.
REQ-033 Branch=1, Zero=1, Addr_result=32'h40 -> next fetch at 32'h40; same with Zero=0 -> opcplus4.
REQ-034 Jal with Instruction[25:0]=26'h10 at PC=32'h8 -> next fetch 32'h40, opcplus4=32'hC; Jrn with Read_data_1=32'h100 -> next fetch 32'h100.
REQ-035 stall=1 for 5 cycles in EXEC -> instr_valid and Instruction stable, no imem_req; PC=32'hFFFF_FFFC sequential -> next fetch 0.
REQ-036 reset_n=0 mid-FETCH with ack one cycle later -> imem_req drops immediately, ack ignored; with IFETCH32_ALIGN_CHK_EN, Jrn to 32'h102 -> fault=1, no further requests.
